// File: rtl/hilo_mul_ctrl_if.sv
// Execute-stage and multiplier-side signals of the HI/LO multiply controller.
// The master modport is the controller; the slave modport is the surrounding pipeline and multiplier.
interface hilo_mul_ctrl_if;
    logic        flush;
    logic        op_valid;
    logic [5:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall_req;
    logic [31:0] mf_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [5:0]  mul_op;
    logic        mul_ce;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    modport master (
        input  flush, op_valid, op, rs_data, rt_data, mul_hi, mul_lo,
        output stall_req, mf_data, hi_out, lo_out, mul_x, mul_y, mul_op, mul_ce
    );

    modport slave (
        output flush, op_valid, op, rs_data, rt_data, mul_hi, mul_lo,
        input  stall_req, mf_data, hi_out, lo_out, mul_x, mul_y, mul_op, mul_ce
    );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO register owner and issue controller for a fixed-latency multiplier:
// launches MULT/MULTU with a start pulse, stalls until the product is due, then captures it.
module hilo_mul_ctrl #(
    parameter int unsigned MUL_LATENCY = 6,
    parameter logic [5:0]  INSN_MFHI   = 6'h10,
    parameter logic [5:0]  INSN_MTHI   = 6'h11,
    parameter logic [5:0]  INSN_MFLO   = 6'h12,
    parameter logic [5:0]  INSN_MTLO   = 6'h13,
    parameter logic [5:0]  INSN_MULT   = 6'h18,
    parameter logic [5:0]  INSN_MULTU  = 6'h19
) (
    input logic             clk,
    input logic             reset,
    hilo_mul_ctrl_if.master bus
);

    localparam logic [3:0] LAT = 4'(MUL_LATENCY);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] x;
    logic [31:0] y;
    logic [5:0]  mop;
    logic        is_mul;

    assign is_mul = (bus.op == INSN_MULT) || (bus.op == INSN_MULTU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            x     <= 32'd0;
            y     <= 32'd0;
            mop   <= 6'd0;
        end else if (bus.flush) begin
            // Flush wins over everything, including the capture cycle.
            state <= StIdle;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.op_valid) begin
                        if (is_mul) begin
                            x     <= bus.rs_data;
                            y     <= bus.rt_data;
                            mop   <= bus.op;
                            state <= StIssue;
                        end else if (bus.op == INSN_MTHI) begin
                            hi <= bus.rs_data;
                        end else if (bus.op == INSN_MTLO) begin
                            lo <= bus.rs_data;
                        end
                    end
                end
                StIssue: begin
                    cnt   <= 4'd1;
                    state <= StWait;
                end
                StWait: begin
                    if (cnt == LAT) begin
                        hi    <= bus.mul_hi;
                        lo    <= bus.mul_lo;
                        cnt   <= 4'd0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        bus.mf_data = 32'd0;
        if (state == StIdle && bus.op_valid && !bus.flush) begin
            if (bus.op == INSN_MFHI) begin
                bus.mf_data = hi;
            end else if (bus.op == INSN_MFLO) begin
                bus.mf_data = lo;
            end
        end
    end

    // The accepting cycle already stalls so upstream holds the MULT until issue completes.
    assign bus.stall_req = (state != StIdle) || (bus.op_valid && is_mul);
    assign bus.mul_ce    = (state == StIssue) && !bus.flush;
    assign bus.mul_x     = x;
    assign bus.mul_y     = y;
    assign bus.mul_op    = mop;
    assign bus.hi_out    = hi;
    assign bus.lo_out    = lo;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural fixed-latency multiplier model.
module tb_hilo_mul_ctrl;
    localparam int unsigned LAT   = 6;
    localparam logic [5:0] MFHI   = 6'h10;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MFLO   = 6'h12;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hilo_mul_ctrl_if b ();

    hilo_mul_ctrl #(
        .MUL_LATENCY (LAT),
        .INSN_MFHI   (MFHI),
        .INSN_MTHI   (MTHI),
        .INSN_MFLO   (MFLO),
        .INSN_MTLO   (MTLO),
        .INSN_MULT   (MULT),
        .INSN_MULTU  (MULTU)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product valid exactly LAT cycles after the start pulse, junk otherwise.
    logic [3:0]  m_cnt;
    logic [63:0] m_prod;

    function automatic logic [63:0] prod_f(input logic [31:0] x, input logic [31:0] y,
                                           input logic [5:0] o);
        logic [63:0] ex;
        logic [63:0] ey;
        if (o == MULT) begin
            ex = {{32{x[31]}}, x};
            ey = {{32{y[31]}}, y};
        end else begin
            ex = {32'd0, x};
            ey = {32'd0, y};
        end
        return ex * ey;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 4'd0;
            m_prod <= 64'd0;
        end else if (b.mul_ce) begin
            m_cnt  <= 4'd1;
            m_prod <= prod_f(b.mul_x, b.mul_y, b.mul_op);
        end else if (m_cnt != 4'd0 && m_cnt < 4'(LAT)) begin
            m_cnt <= m_cnt + 4'd1;
        end else begin
            m_cnt <= 4'd0;
        end
    end

    assign b.mul_hi = (m_cnt == 4'(LAT)) ? m_prod[63:32] : 32'hDEADBEEF;
    assign b.mul_lo = (m_cnt == 4'(LAT)) ? m_prod[31:0]  : 32'hBADC0FFE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl);
        b.op_valid = v;
        b.op       = o;
        b.rs_data  = rs;
        b.rt_data  = rt;
        b.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        #1;
        chk("rst_hi", b.hi_out, 32'd0);
        chk("rst_lo", b.lo_out, 32'd0);
        chk("rst_mul_x", b.mul_x, 32'd0);
        chk("rst_mul_y", b.mul_y, 32'd0);
        chk("rst_mul_op", 32'(b.mul_op), 32'd0);
        chk("rst_ce", 32'(b.mul_ce), 32'd0);
        chk("rst_stall", 32'(b.stall_req), 32'd0);
        reset = 1'b0;

        // MFHI / MFLO after reset
        tick();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mfhi_reset", b.mf_data, 32'd0);
        chk("mfhi_reset_stall", 32'(b.stall_req), 32'd0);
        tick();
        drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mflo_reset", b.mf_data, 32'd0);

        // MTHI / MTLO then read back
        tick();
        drive(1'b1, MTHI, 32'h12345678, 32'd0, 1'b0);
        #1;
        chk("mthi_stall", 32'(b.stall_req), 32'd0);
        tick();
        drive(1'b1, MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
        #1;
        chk("mtlo_stall", 32'(b.stall_req), 32'd0);
        tick();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mfhi_val", b.mf_data, 32'h12345678);
        tick();
        drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mflo_val", b.mf_data, 32'h9ABCDEF0);
        chk("mflo_stall", 32'(b.stall_req), 32'd0);

        // Signed MULT: -2 * 3 = -6
        tick();
        drive(1'b1, MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        #1;
        chk("mult_c0_stall", 32'(b.stall_req), 32'd1);
        chk("mult_c0_ce", 32'(b.mul_ce), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
            #1;
            chk($sformatf("mult_c%0d_ce", c), 32'(b.mul_ce), (c == 1) ? 32'd1 : 32'd0);
            chk($sformatf("mult_c%0d_stall", c), 32'(b.stall_req), (c <= 7) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 7) begin
                chk($sformatf("mult_c%0d_x", c), b.mul_x, 32'hFFFFFFFE);
                chk($sformatf("mult_c%0d_y", c), b.mul_y, 32'd3);
                chk($sformatf("mult_c%0d_op", c), 32'(b.mul_op), 32'(MULT));
            end
            if (c == 7) chk("mult_c7_hi_old", b.hi_out, 32'h12345678);
        end
        chk("mult_hi", b.hi_out, 32'hFFFFFFFF);
        chk("mult_lo", b.lo_out, 32'hFFFFFFFA);

        // MULTU with MFLO held under the stall
        tick();
        drive(1'b1, MULTU, 32'h00010000, 32'h00010000, 1'b0);
        #1;
        chk("multu_c0_stall", 32'(b.stall_req), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            drive(1'b1, MFLO, 32'd0, 32'd0, 1'b0);
            #1;
            if (c == 3) chk("multu_op", 32'(b.mul_op), 32'(MULTU));
            if (c == 7) chk("multu_c7_stall", 32'(b.stall_req), 32'd1);
        end
        chk("multu_c8_stall", 32'(b.stall_req), 32'd0);
        chk("multu_mflo", b.mf_data, 32'd0);
        chk("multu_hi", b.hi_out, 32'd1);

        // Flush in the middle of a multiply
        tick();
        drive(1'b1, MTHI, 32'hAAAA0001, 32'd0, 1'b0);
        tick();
        drive(1'b1, MTLO, 32'h55550002, 32'd0, 1'b0);
        tick();
        drive(1'b1, MULT, 32'd7, 32'd9, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            drive(1'b0, 6'd0, 32'd0, 32'd0, c == 4);
        end
        #1;
        chk("flush_c4_ce", 32'(b.mul_ce), 32'd0);
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("flush_c5_stall", 32'(b.stall_req), 32'd0);
        chk("flush_c5_hi", b.hi_out, 32'hAAAA0001);
        chk("flush_c5_lo", b.lo_out, 32'h55550002);
        for (int c = 6; c <= 8; c++) tick();
        chk("flush_c8_hi", b.hi_out, 32'hAAAA0001);
        chk("flush_c8_lo", b.lo_out, 32'h55550002);

        // Flush in IDLE discards MTHI and MFHI
        drive(1'b1, MTHI, 32'h0000DEAD, 32'd0, 1'b1);
        #1;
        chk("flush_idle_mf", b.mf_data, 32'd0);
        tick();
        drive(1'b1, MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        chk("flush_idle_hi", b.mf_data, 32'hAAAA0001);

        // Asynchronous reset in cycle 3 of a multiply
        tick();
        drive(1'b1, MULT, 32'd5, 32'd6, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("arst_hi", b.hi_out, 32'd0);
        chk("arst_lo", b.lo_out, 32'd0);
        chk("arst_x", b.mul_x, 32'd0);
        chk("arst_y", b.mul_y, 32'd0);
        chk("arst_op", 32'(b.mul_op), 32'd0);
        chk("arst_stall", 32'(b.stall_req), 32'd0);
        chk("arst_ce", 32'(b.mul_ce), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 5; c <= 8; c++) tick();
        chk("arst_c8_hi", b.hi_out, 32'd0);
        chk("arst_c8_lo", b.lo_out, 32'd0);
        chk("arst_c8_stall", 32'(b.stall_req), 32'd0);

        // Flush in the capture cycle: no HI/LO write
        tick();
        drive(1'b1, MULTU, 32'd2, 32'd3, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            drive(1'b0, 6'd0, 32'd0, 32'd0, c == 7);
        end
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("capflush_lo", b.lo_out, 32'd0);
        chk("capflush_stall", 32'(b.stall_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
